timer_step_decoder: RTL and testbench
=====================================

# timer_step_decoder

Receive-side companion to the up/down seconds timer. It samples the timer's 3-bit count bus every clock and classifies each change as an up step, down step, wrap, or illegal jump. From that it derives direction, step pulses, a step total, the interval between steps, a stall flag and a sticky error flag. It sits between the timer and the display/multiplexer logic, which consume the pulses instead of re-decoding the raw count.

## Interface
- MAX_VALUE, 5: highest legal count; the timer cycles 0..MAX_VALUE. Legal range is 2..7.
- TIMEOUT_TICKS, 50000000: cycles without a legal step before `stalled` asserts. Must be at least 1.
- clock  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- count_in  input  3  timer count; synchronous to `clock`.
- clear_error  input  1  one-cycle request to clear `error`.
- dir_out  output  1  direction of the last legal step: 1 = up, 0 = down.
- step_pulse  output  1  one-cycle pulse per legal step, including wraps.
- wrap_pulse  output  1  one-cycle pulse on a MAX_VALUE→0 or 0→MAX_VALUE step.
- error  output  1  sticky; set on any illegal transition.
- stalled  output  1  no legal step for TIMEOUT_TICKS cycles.
- step_total  output  16  count of legal steps; wraps modulo 2^16.
- last_interval  output  32  cycles between the two most recent legal steps.

## Operation
- States: INIT, TRACK, FAULT. Reset enters INIT.
- INIT
  - One cycle long. Captures `count_in` into `prev`; no pulses.
  - Next state is TRACK if `count_in` ≤ MAX_VALUE.
  - Otherwise sets `error` and goes to FAULT.
- TRACK, evaluated each cycle on `count_in` (cur) against `prev`:
  - cur == prev: no step.
  - Up step: cur == prev+1 with prev < MAX_VALUE, or prev == MAX_VALUE and cur == 0 (wrap).
  - Down step: cur == prev−1 with prev > 0, or prev == 0 and cur == MAX_VALUE (wrap).
  - Anything else is illegal, including cur > MAX_VALUE. An illegal change sets `error`, produces no pulse, leaves `dir_out` and the counters unchanged, and moves to FAULT.
  - `prev` ← cur every cycle.
- FAULT
  - Resynchronises: the first cycle with `count_in` ≤ MAX_VALUE loads `prev` and returns to TRACK without a pulse.
  - Out-of-range values keep the block in FAULT.
- On a legal step:
  - `step_pulse` = 1; `wrap_pulse` = 1 if it was a wrap.
  - `dir_out` ← 1 for up, 0 for down.
  - `step_total` += 1.
  - `last_interval` ← `interval_cnt` + 1; `interval_cnt` ← 0.
  - `stalled` ← 0.
- `interval_cnt` (32 bits, internal):
  - Increments on every cycle without a legal step, in all states, and saturates at 2^32−1.
  - `last_interval` loads the saturated value, not a wrapped one.
- `stalled` is set when `interval_cnt` reaches TIMEOUT_TICKS and stays set until the next legal step.
- `clear_error` clears `error` on the next edge. If an illegal transition occurs in the same cycle, `error` stays 1.
- Reset asserted mid-operation: all state is cleared immediately (asynchronous); any in-flight pulse is dropped.

## Timing
- Reset values: `dir_out`=1; all other outputs 0; `prev`=0; `interval_cnt`=0; state INIT.
- All outputs are registered.
- A `count_in` change present before edge N produces the pulses and counter updates valid after edge N, for exactly one cycle.
- Back-to-back changes on consecutive cycles each produce their own pulse. `last_interval` = 1 in that case.
- The first legal step after reset reports `last_interval` = cycles since leaving INIT, +1.
- `stalled` rises on the edge where `interval_cnt` becomes TIMEOUT_TICKS. It falls on the edge that registers the next legal step.
- `error` rises on the edge that registers the illegal transition. It falls on the edge after `clear_error`, unless a new illegal transition coincides with that edge.

## Test plan
- Reset: hold reset_n=0 with count_in=3 → `dir_out`=1, every other output 0. Release → no pulse on the first cycle; state TRACK.
- Up sequence 0,1,2,3,4,5,0, one value per 4 cycles →
  - 6 `step_pulse`, 1 `wrap_pulse` (on 5→0);
  - `dir_out`=1, `step_total`=6, `last_interval`=4, `error`=0.
- Down sequence 2,1,0,5,4 →
  - 4 steps, `wrap_pulse` on 0→5;
  - `dir_out`=0 after the first step;
  - then 4→5 → `dir_out` returns to 1.
- Illegal jump 1→4 →
  - `error`=1, no pulse, `step_total` unchanged;
  - then 4→5 → legal up step counted.
  - Value 7 → `error`=1 and FAULT until count_in ≤ 5.
- Stall with TIMEOUT_TICKS=10: hold count 2 → `stalled`=1 exactly 10 cycles after the last step; 2→3 → `stalled`=0 and `last_interval`=11 when the step comes on the 11th cycle.
- Clear and reset:
  - `clear_error` alone → `error`=0.
  - `clear_error` in the same cycle as 3→0 (illegal) → `error` stays 1.
  - reset_n pulsed mid-sequence → all outputs back to their reset values immediately.

Source files
------------

// File: rtl/timer_step_decoder.sv
// Decodes the seconds-timer count bus into direction, step/wrap pulses,
// a step total, the inter-step interval and stall/error flags.
module timer_step_decoder #(
    parameter int MAX_VALUE     = 5,
    parameter int TIMEOUT_TICKS = 50000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  count_in,
    input  logic        clear_error,
    output logic        dir_out,
    output logic        step_pulse,
    output logic        wrap_pulse,
    output logic        error,
    output logic        stalled,
    output logic [15:0] step_total,
    output logic [31:0] last_interval
);

    typedef enum logic [1:0] {INIT, TRACK, FAULT} state_t;

    localparam logic [2:0]  MAX     = 3'(MAX_VALUE);
    localparam logic [31:0] TIMEOUT = 32'(TIMEOUT_TICKS);
    localparam logic [31:0] CNT_SAT = 32'hFFFF_FFFF;

    state_t      state, state_next;
    logic [2:0]  prev;
    logic [31:0] interval_cnt, interval_next, cnt_inc;
    logic        in_range, up_step, down_step, wrap_step, legal, illegal;
    logic        dir_next, step_next, wrap_next, error_next, stalled_next;
    logic [15:0] total_next;
    logic [31:0] last_next;

    // NOTE: every signal gets a default at the top so no path can infer a latch.
    always_comb begin
        state_next    = state;
        dir_next      = dir_out;
        step_next     = 1'b0;
        wrap_next     = 1'b0;
        total_next    = step_total;
        last_next     = last_interval;
        stalled_next  = stalled;

        in_range  = (count_in <= MAX);
        up_step   = ((prev < MAX) && (count_in == prev + 3'd1)) ||
                    ((prev == MAX) && (count_in == 3'd0));
        down_step = ((prev > 3'd0) && (count_in == prev - 3'd1)) ||
                    ((prev == 3'd0) && (count_in == MAX));
        wrap_step = ((prev == MAX) && (count_in == 3'd0)) ||
                    ((prev == 3'd0) && (count_in == MAX));
        legal     = (state == TRACK) && in_range && (up_step || down_step);
        illegal   = ((state == INIT) && !in_range) ||
                    ((state == TRACK) && (count_in != prev) && !legal);

        // Saturate rather than wrap so a very long gap never looks short.
        cnt_inc       = (interval_cnt == CNT_SAT) ? interval_cnt : interval_cnt + 32'd1;
        interval_next = cnt_inc;

        unique case (state)
            INIT:    state_next = in_range ? TRACK : FAULT;
            TRACK:   state_next = illegal ? FAULT : TRACK;
            FAULT:   state_next = in_range ? TRACK : FAULT;
            default: state_next = INIT;
        endcase

        if (legal) begin
            step_next     = 1'b1;
            wrap_next     = wrap_step;
            dir_next      = up_step;
            total_next    = step_total + 16'd1;
            last_next     = cnt_inc;
            interval_next = 32'd0;
            stalled_next  = 1'b0;
        end else if (cnt_inc == TIMEOUT) begin
            stalled_next = 1'b1;
        end

        // A coincident illegal transition wins over the clear request.
        error_next = illegal ? 1'b1 : (clear_error ? 1'b0 : error);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= INIT;
            prev          <= 3'd0;
            interval_cnt  <= 32'd0;
            dir_out       <= 1'b1;
            step_pulse    <= 1'b0;
            wrap_pulse    <= 1'b0;
            error         <= 1'b0;
            stalled       <= 1'b0;
            step_total    <= 16'd0;
            last_interval <= 32'd0;
        end else begin
            state         <= state_next;
            prev          <= count_in;
            interval_cnt  <= interval_next;
            dir_out       <= dir_next;
            step_pulse    <= step_next;
            wrap_pulse    <= wrap_next;
            error         <= error_next;
            stalled       <= stalled_next;
            step_total    <= total_next;
            last_interval <= last_next;
        end
    end

endmodule

// File: tb/tb_timer_step_decoder.sv
// Directed bench for timer_step_decoder with MAX_VALUE=5, TIMEOUT_TICKS=10.
module tb_timer_step_decoder;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  count_in = 3'd0;
    logic        clear_error = 1'b0;
    logic        dir_out, step_pulse, wrap_pulse, error, stalled;
    logic [15:0] step_total;
    logic [31:0] last_interval;

    int checks = 0;
    int errors = 0;
    int n_steps, n_wraps;
    logic first_step, first_wrap;

    timer_step_decoder #(.MAX_VALUE(5), .TIMEOUT_TICKS(10)) dut (
        .clock(clock), .reset_n(reset_n), .count_in(count_in), .clear_error(clear_error),
        .dir_out(dir_out), .step_pulse(step_pulse), .wrap_pulse(wrap_pulse), .error(error),
        .stalled(stalled), .step_total(step_total), .last_interval(last_interval)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive a value, hold it n cycles, and tally the pulses seen.
    task automatic hold(input logic [2:0] v, input int n);
        count_in = v;
        for (int i = 0; i < n; i++) begin
            tick();
            if (i == 0) begin
                first_step = step_pulse;
                first_wrap = wrap_pulse;
            end
            if (step_pulse) n_steps++;
            if (wrap_pulse) n_wraps++;
        end
    endtask

    task automatic apply_reset(input logic [2:0] v);
        reset_n  = 1'b0;
        count_in = v;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();  // INIT cycle
        n_steps = 0;
        n_wraps = 0;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        count_in = 3'd3;
        repeat (2) tick();
        checks++; if (dir_out !== 1'b1) begin errors++; $display("FAIL reset_dir: got %0d want 1", dir_out); end
        checks++; if ({step_pulse, wrap_pulse, error, stalled} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {step_pulse, wrap_pulse, error, stalled}); end
        checks++; if (step_total !== 16'd0 || last_interval !== 32'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d want 0/0", step_total, last_interval); end
        reset_n = 1'b1;
        tick();
        checks++; if (step_pulse !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL init_cycle: got pulse %0d err %0d want 0 0", step_pulse, error); end
        hold(3'd3, 2);
        hold(3'd4, 1);
        checks++; if (step_pulse !== 1'b1) begin errors++; $display("FAIL init_to_track: got %0d want 1", step_pulse); end
    endtask

    task automatic test_up();
        apply_reset(3'd0);
        hold(3'd0, 4);
        for (int v = 1; v <= 5; v++) hold(3'(v), 4);
        hold(3'd0, 4);
        checks++; if (first_wrap !== 1'b1) begin errors++; $display("FAIL up_wrap_on_5_0: got %0d want 1", first_wrap); end
        checks++; if (n_steps != 6 || n_wraps != 1) begin errors++; $display("FAIL up_pulses: got %0d/%0d want 6/1", n_steps, n_wraps); end
        checks++; if (dir_out !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL up_dir_err: got %0d/%0d want 1/0", dir_out, error); end
        checks++; if (step_total !== 16'd6) begin errors++; $display("FAIL up_total: got %0d want 6", step_total); end
        checks++; if (last_interval !== 32'd4) begin errors++; $display("FAIL up_interval: got %0d want 4", last_interval); end
    endtask

    task automatic test_down();
        apply_reset(3'd2);
        hold(3'd2, 3);
        hold(3'd1, 4);
        checks++; if (dir_out !== 1'b0) begin errors++; $display("FAIL down_dir: got %0d want 0", dir_out); end
        hold(3'd0, 4);
        hold(3'd5, 4);
        checks++; if (first_wrap !== 1'b1) begin errors++; $display("FAIL down_wrap_on_0_5: got %0d want 1", first_wrap); end
        hold(3'd4, 4);
        checks++; if (n_steps != 4 || n_wraps != 1 || step_total !== 16'd4) begin errors++; $display("FAIL down_counts: got %0d/%0d/%0d want 4/1/4", n_steps, n_wraps, step_total); end
        hold(3'd5, 4);
        checks++; if (first_step !== 1'b1 || dir_out !== 1'b1 || step_total !== 16'd5) begin errors++; $display("FAIL down_reverse: got %0d/%0d/%0d want 1/1/5", first_step, dir_out, step_total); end
    endtask

    task automatic test_illegal();
        for (int v = 4; v >= 1; v--) hold(3'(v), 4);
        hold(3'd4, 3);
        checks++; if (first_step !== 1'b0 || error !== 1'b1 || step_total !== 16'd9) begin errors++; $display("FAIL jump_1_4: got pulse %0d err %0d total %0d want 0 1 9", first_step, error, step_total); end
        hold(3'd5, 2);
        checks++; if (first_step !== 1'b1 || step_total !== 16'd10 || dir_out !== 1'b1) begin errors++; $display("FAIL after_jump_step: got %0d/%0d/%0d want 1/10/1", first_step, step_total, dir_out); end
        clear_error = 1'b1;
        tick();
        clear_error = 1'b0;
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL clear_alone: got %0d want 0", error); end
        n_steps = 0;
        hold(3'd7, 3);
        checks++; if (error !== 1'b1 || n_steps != 0) begin errors++; $display("FAIL out_of_range: got err %0d steps %0d want 1 0", error, n_steps); end
        hold(3'd5, 1);
        checks++; if (first_step !== 1'b0) begin errors++; $display("FAIL resync_no_pulse: got %0d want 0", first_step); end
        hold(3'd0, 4);
        checks++; if (first_step !== 1'b1 || first_wrap !== 1'b1 || step_total !== 16'd11) begin errors++; $display("FAIL resync_track: got %0d/%0d/%0d want 1/1/11", first_step, first_wrap, step_total); end
    endtask

    task automatic test_stall();
        hold(3'd1, 4);
        hold(3'd2, 10);
        checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL stall_early: got %0d want 0 after 9 idle cycles", stalled); end
        tick();
        checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL stall_rise: got %0d want 1 after 10 idle cycles", stalled); end
        hold(3'd3, 1);
        checks++; if (first_step !== 1'b1 || stalled !== 1'b0) begin errors++; $display("FAIL stall_clear: got pulse %0d stalled %0d want 1 0", first_step, stalled); end
        checks++; if (last_interval !== 32'd11) begin errors++; $display("FAIL stall_interval: got %0d want 11", last_interval); end
    endtask

    task automatic test_clear_coincide();
        count_in    = 3'd0;
        clear_error = 1'b1;
        tick();
        clear_error = 1'b0;
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL clear_vs_illegal: got %0d want 1", error); end
        clear_error = 1'b1;
        tick();
        clear_error = 1'b0;
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL clear_after: got %0d want 0", error); end
    endtask

    task automatic test_back_to_back();
        hold(3'd0, 1);
        for (int v = 1; v <= 3; v++) begin
            hold(3'(v), 1);
            checks++; if (first_step !== 1'b1) begin errors++; $display("FAIL b2b_pulse_%0d: got %0d want 1", v, first_step); end
        end
        checks++; if (last_interval !== 32'd1) begin errors++; $display("FAIL b2b_interval: got %0d want 1", last_interval); end
    endtask

    task automatic test_reset_mid();
        hold(3'd4, 1);
        checks++; if (step_pulse !== 1'b1 || step_total === 16'd0) begin errors++; $display("FAIL mid_pre: got pulse %0d total %0d want 1 nonzero", step_pulse, step_total); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (step_pulse !== 1'b0 || dir_out !== 1'b1 || step_total !== 16'd0 || last_interval !== 32'd0) begin errors++; $display("FAIL mid_reset: got %0d/%0d/%0d/%0d want 0/1/0/0", step_pulse, dir_out, step_total, last_interval); end
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        n_steps = 0;
        n_wraps = 0;
        test_reset();
        test_up();
        test_down();
        test_illegal();
        test_stall();
        test_clear_coincide();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
